// File: rtl/demux_stream_skid.sv
// demux_stream_skid
// Registered 1-to-NUM_OUT stream demultiplexer with a 2-entry skid buffer.
// Each accepted word carries a destination index and is presented on a shared
// data bus with a one-hot valid naming its channel. Words leave strictly in
// acceptance order. in_rdy is a flop, so no out_rdy bit can reach it
// combinationally. Words whose index is out of range are accepted, discarded
// and counted.
module demux_stream_skid #(
    parameter int DATA_W  = 64,
    parameter int NUM_OUT = 8,
    parameter int SEL_W   = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic [NUM_OUT-1:0] out_vld,
    input  logic [NUM_OUT-1:0] out_rdy,
    output logic [DATA_W-1:0]  out_data,
    output logic               drop_pls,
    output logic [CNT_W-1:0]   drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  headData_q, headData_d;
    logic [SEL_W-1:0]   headSel_q, headSel_d;
    logic [DATA_W-1:0]  tailData_q, tailData_d;
    logic [SEL_W-1:0]   tailSel_q, tailSel_d;
    logic               inRdy_q, inRdy_d;
    logic [NUM_OUT-1:0] outVld_q, outVld_d;
    logic               dropPls_q, dropPls_d;
    logic [CNT_W-1:0]   dropCnt_q, dropCnt_d;

    logic inFire;
    logic selOk;
    logic store;
    logic drop;
    logic outFire;

    // Handshake decode: which transfers happen at the coming edge, and whether the
    // incoming word is kept (valid index) or swallowed (out-of-range index).
    always_comb begin
        inFire  = in_vld && inRdy_q;
        selOk   = (32'(in_sel) < 32'(NUM_OUT));
        store   = inFire && selOk;
        drop    = inFire && !selOk;
        outFire = |(outVld_q & out_rdy);
    end

    // Next-state of the skid buffer; the head entry always drives the outputs, and
    // the head is zeroed when the buffer empties so out_data never shows stale data.
    always_comb begin
        state_d    = state_q;
        headData_d = headData_q;
        headSel_d  = headSel_q;
        tailData_d = tailData_q;
        tailSel_d  = tailSel_q;
        unique case (state_q)
            EMPTY: begin
                if (store) begin
                    state_d    = ONE;
                    headData_d = in_data;
                    headSel_d  = in_sel;
                end
            end
            ONE: begin
                if (store && outFire) begin
                    headData_d = in_data;
                    headSel_d  = in_sel;
                end else if (store) begin
                    state_d    = TWO;
                    tailData_d = in_data;
                    tailSel_d  = in_sel;
                end else if (outFire) begin
                    state_d    = EMPTY;
                    headData_d = '0;
                    headSel_d  = '0;
                end
            end
            TWO: begin
                if (outFire) begin
                    state_d    = ONE;
                    headData_d = tailData_q;
                    headSel_d  = tailSel_q;
                    tailData_d = '0;
                    tailSel_d  = '0;
                end
            end
            default: begin
                state_d    = EMPTY;
                headData_d = '0;
                headSel_d  = '0;
                tailData_d = '0;
                tailSel_d  = '0;
            end
        endcase
    end

    // Registered outputs derived from the next state: ready unless full, and a
    // one-hot valid decoded from the next head index.
    always_comb begin
        inRdy_d  = (state_d != TWO);
        outVld_d = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            outVld_d[i] = (state_d != EMPTY) && (headSel_d == SEL_W'(i));
        end
        dropPls_d = drop;
        dropCnt_d = dropCnt_q;
        if (drop && (dropCnt_q != {CNT_W{1'b1}})) begin
            dropCnt_d = dropCnt_q + CNT_W'(1);
        end
    end

    // All state and registered outputs; reset discards both entries and the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            headData_q <= '0;
            headSel_q  <= '0;
            tailData_q <= '0;
            tailSel_q  <= '0;
            inRdy_q    <= 1'b0;
            outVld_q   <= '0;
            dropPls_q  <= 1'b0;
            dropCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            headData_q <= headData_d;
            headSel_q  <= headSel_d;
            tailData_q <= tailData_d;
            tailSel_q  <= tailSel_d;
            inRdy_q    <= inRdy_d;
            outVld_q   <= outVld_d;
            dropPls_q  <= dropPls_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    assign in_rdy   = inRdy_q;
    assign out_vld  = outVld_q;
    assign out_data = headData_q;
    assign drop_pls = dropPls_q;
    assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_demux_stream_skid.sv
// tb_demux_stream_skid
// Two instances: the default 8-channel build, and a 6-channel build with a 4-bit
// drop counter so out-of-range indices and counter saturation can be exercised.
// A queue per instance holds accepted words in order; every output transfer
// pops and compares the head of that queue.
module tb_demux_stream_skid;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        aVld = 1'b0;
    logic        aRdy;
    logic [63:0] aData = '0;
    logic [5:0]  aSel = '0;
    logic [7:0]  aOutVld;
    logic [7:0]  aOutRdy = '0;
    logic [63:0] aOutData;
    logic        aDropPls;
    logic [15:0] aDropCnt;

    logic        bVld = 1'b0;
    logic        bRdy;
    logic [63:0] bData = '0;
    logic [2:0]  bSel = '0;
    logic [5:0]  bOutVld;
    logic [5:0]  bOutRdy = '0;
    logic [63:0] bOutData;
    logic        bDropPls;
    logic [3:0]  bDropCnt;

    int checks = 0;
    int passes = 0;
    int aPops  = 0;
    int bPops  = 0;

    typedef struct {
        logic [63:0] data;
        int          sel;
    } word_t;

    word_t aQ[$];
    word_t bQ[$];

    typedef struct {
        logic [2:0]  sel;
        logic [63:0] data;
        logic        expPls;
        logic [3:0]  expCnt;
    } vec_t;

    demux_stream_skid uA (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (aVld),
        .in_rdy   (aRdy),
        .in_data  (aData),
        .in_sel   (aSel),
        .out_vld  (aOutVld),
        .out_rdy  (aOutRdy),
        .out_data (aOutData),
        .drop_pls (aDropPls),
        .drop_cnt (aDropCnt)
    );

    demux_stream_skid #(
        .DATA_W  (64),
        .NUM_OUT (6),
        .SEL_W   (3),
        .CNT_W   (4)
    ) uB (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (bVld),
        .in_rdy   (bRdy),
        .in_data  (bData),
        .in_sel   (bSel),
        .out_vld  (bOutVld),
        .out_rdy  (bOutRdy),
        .out_data (bOutData),
        .drop_pls (bDropPls),
        .drop_cnt (bDropCnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual === required) passes++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    endtask

    task automatic applyStimulusA(input logic vld, input logic [63:0] data, input logic [5:0] sel);
        @(posedge clk);
        #1;
        aVld  = vld;
        aData = data;
        aSel  = sel;
    endtask

    task automatic applyStimulusB(input logic vld, input logic [63:0] data, input logic [2:0] sel);
        @(posedge clk);
        #1;
        bVld  = vld;
        bData = data;
        bSel  = sel;
    endtask

    logic        aStalled = 1'b0;
    logic [7:0]  aPrevVld;
    logic [63:0] aPrevData;

    // Scoreboard for the 8-channel instance: pop on output transfer, hold check
    // while stalled, push on accepted input.
    always @(negedge clk) begin
        if (!rst) begin
            aQ.delete();
            aStalled = 1'b0;
        end else begin
            if (aStalled) begin
                checkOutput("holdVldA", 64'(aOutVld), 64'(aPrevVld));
                checkOutput("holdDataA", aOutData, aPrevData);
            end
            if (|(aOutVld & aOutRdy)) begin
                if (aQ.size() == 0) begin
                    checkOutput("unexpectedOutA", 64'(aOutVld), 64'd0);
                end else begin
                    word_t w;
                    logic [7:0] expVld;
                    w = aQ.pop_front();
                    expVld = 8'd1 << w.sel;
                    checkOutput("dataA", aOutData, w.data);
                    checkOutput("vldA", 64'(aOutVld), 64'(expVld));
                    aPops++;
                end
            end
            aStalled  = (aOutVld != '0) && !(|(aOutVld & aOutRdy));
            aPrevVld  = aOutVld;
            aPrevData = aOutData;
            if (aVld && aRdy && (aSel < 6'd8)) aQ.push_back('{aData, int'(aSel)});
        end
    end

    // Scoreboard for the 6-channel instance; out-of-range words are never queued.
    always @(negedge clk) begin
        if (!rst) begin
            bQ.delete();
        end else begin
            if (|(bOutVld & bOutRdy)) begin
                if (bQ.size() == 0) begin
                    checkOutput("unexpectedOutB", 64'(bOutVld), 64'd0);
                end else begin
                    word_t w;
                    logic [5:0] expVld;
                    w = bQ.pop_front();
                    expVld = 6'd1 << w.sel;
                    checkOutput("dataB", bOutData, w.data);
                    checkOutput("vldB", 64'(bOutVld), 64'(expVld));
                    bPops++;
                end
            end
            if (bVld && bRdy && (bSel < 3'd6)) bQ.push_back('{bData, int'(bSel)});
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int   popsBefore;

        vecs[0] = '{3'd1, 64'h10, 1'b0, 4'd0};
        vecs[1] = '{3'd6, 64'h11, 1'b1, 4'd1};
        vecs[2] = '{3'd2, 64'h12, 1'b0, 4'd1};
        vecs[3] = '{3'd7, 64'h13, 1'b1, 4'd2};
        vecs[4] = '{3'd5, 64'h14, 1'b0, 4'd2};

        // Reset held for three cycles with in_vld high.
        #1;
        rst  = 1'b0;
        aVld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstOutVld", 64'(aOutVld), 64'd0);
        checkOutput("rstInRdy", 64'(aRdy), 64'd0);
        checkOutput("rstDropCnt", 64'(aDropCnt), 64'd0);
        checkOutput("rstOutData", aOutData, 64'd0);
        checkOutput("rstDropCntB", 64'(bDropCnt), 64'd0);
        aVld = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("relInRdy", 64'(aRdy), 64'd1);

        // Streaming: 16 back-to-back words, all consumers ready.
        $display("[TB] streaming");
        aOutRdy = 8'hFF;
        aPops   = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            checkOutput("streamInRdy", 64'(aRdy), 64'd1);
            aVld  = 1'b1;
            aData = 64'(i);
            aSel  = 6'(i % 8);
        end
        applyStimulusA(1'b0, 64'd0, 6'd0);
        @(posedge clk);
        #2;
        checkOutput("streamPops", 64'(aPops), 64'd16);
        checkOutput("streamEmpty", 64'(aOutVld), 64'd0);

        // Backpressure: fill both entries, wrong channel ready, then drain in order.
        $display("[TB] backpressure");
        aOutRdy = 8'h00;
        applyStimulusA(1'b1, 64'hA, 6'd3);
        applyStimulusA(1'b1, 64'hB, 6'd5);
        applyStimulusA(1'b0, 64'd0, 6'd0);
        checkOutput("bpFullRdy", 64'(aRdy), 64'd0);
        checkOutput("bpHeadVld", 64'(aOutVld), 64'h08);
        checkOutput("bpHeadData", aOutData, 64'hA);
        aOutRdy = 8'h20;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("bpStallVld", 64'(aOutVld), 64'h08);
            checkOutput("bpStallRdy", 64'(aRdy), 64'd0);
        end
        aOutRdy = 8'h08;
        @(posedge clk);
        #1;
        checkOutput("bpDrainRdy", 64'(aRdy), 64'd1);
        checkOutput("bpTailVld", 64'(aOutVld), 64'h20);
        checkOutput("bpTailData", aOutData, 64'hB);
        aOutRdy = 8'h20;
        @(posedge clk);
        #1;
        checkOutput("bpEmptyVld", 64'(aOutVld), 64'd0);
        checkOutput("bpEmptyData", aOutData, 64'd0);

        // Back-to-back words to the same channel through the ONE state.
        aOutRdy    = 8'hFF;
        popsBefore = aPops;
        applyStimulusA(1'b1, 64'h51, 6'd2);
        applyStimulusA(1'b1, 64'h52, 6'd2);
        applyStimulusA(1'b0, 64'd0, 6'd0);
        @(posedge clk);
        #1;
        checkOutput("sameChanPops", 64'(aPops - popsBefore), 64'd2);

        // Invalid selects on the 6-channel build, table driven.
        $display("[TB] invalid select");
        bOutRdy = 6'h3F;
        bPops   = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulusB(1'b1, vecs[i].data, vecs[i].sel);
            checkOutput("tblInRdy", 64'(bRdy), 64'd1);
            applyStimulusB(1'b0, 64'd0, 3'd0);
            checkOutput("tblDropPls", 64'(bDropPls), 64'(vecs[i].expPls));
            checkOutput("tblDropCnt", 64'(bDropCnt), 64'(vecs[i].expCnt));
        end
        applyStimulusB(1'b0, 64'd0, 3'd0);
        checkOutput("tblPops", 64'(bPops), 64'd3);

        // Saturation: 20 more dropped words on top of the two already counted.
        $display("[TB] saturation");
        for (int i = 0; i < 20; i++) begin
            applyStimulusB(1'b1, 64'(i), 3'(6 + (i % 2)));
        end
        applyStimulusB(1'b0, 64'd0, 3'd0);
        checkOutput("satCnt", 64'(bDropCnt), 64'd15);
        checkOutput("satPls", 64'(bDropPls), 64'd1);
        applyStimulusB(1'b0, 64'd0, 3'd0);
        checkOutput("satCntHold", 64'(bDropCnt), 64'd15);
        checkOutput("satPlsLow", 64'(bDropPls), 64'd0);
        checkOutput("satNoOut", 64'(bOutVld), 64'd0);

        // Reset while full: outputs clear asynchronously, then a fresh word goes alone.
        $display("[TB] mid-stream reset");
        aOutRdy = 8'h00;
        applyStimulusA(1'b1, 64'hE1, 6'd4);
        applyStimulusA(1'b1, 64'hE2, 6'd6);
        applyStimulusA(1'b0, 64'd0, 6'd0);
        checkOutput("mrFullRdy", 64'(aRdy), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mrOutVld", 64'(aOutVld), 64'd0);
        checkOutput("mrOutData", aOutData, 64'd0);
        checkOutput("mrInRdy", 64'(aRdy), 64'd0);
        checkOutput("mrDropCntB", 64'(bDropCnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulusA(1'b0, 64'd0, 6'd0);
        checkOutput("mrRelRdy", 64'(aRdy), 64'd1);
        checkOutput("mrRelEmpty", 64'(aOutVld), 64'd0);
        aOutRdy    = 8'hFF;
        popsBefore = aPops;
        applyStimulusA(1'b1, 64'hC, 6'd1);
        applyStimulusA(1'b0, 64'd0, 6'd0);
        checkOutput("mrCVld", 64'(aOutVld), 64'h02);
        checkOutput("mrCData", aOutData, 64'hC);
        applyStimulusA(1'b0, 64'd0, 6'd0);
        checkOutput("mrCGone", 64'(aOutVld), 64'd0);
        checkOutput("mrCPops", 64'(aPops - popsBefore), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
